// File: rtl/vga_stream_out_if.sv
// vga_stream_out_if: valid/ready pixel stream carrying colour, sideband
// and a start-of-frame flag; master drives data, slave drives ready.
interface vga_stream_out_if #(
  parameter int PIXEL_BITS = 12,
  parameter int META_BITS  = 4
);
  logic [PIXEL_BITS-1:0] pixel;
  logic [META_BITS-1:0]  meta;
  logic                  sof;
  logic                  valid;
  logic                  ready;

  modport master (
    output pixel,
    output meta,
    output sof,
    output valid,
    input  ready
  );

  modport slave (
    input  pixel,
    input  meta,
    input  sof,
    input  valid,
    output ready
  );
endinterface

// File: rtl/vga_stream_out.sv
// vga_stream_out: turns a pixel stream into timed VGA signals, one beat
// per visible pixel, with underflow/SOF checks and resync at (0,0).
// Ports: clk, reset_n (async, active low), enable; s = pixel stream
// slave; vga_* registered colour/meta/sync/de/position outputs;
// frame_start, err_pulse one-cycle pulses; err_cnt saturating count.
module vga_stream_out #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0,
  parameter int PIXEL_BITS    = 12,
  parameter int META_BITS     = 4,
  parameter int ERR_BITS      = 8,
  localparam int COLOR_BITS   = PIXEL_BITS / 3,
  localparam int H_WHOLE_LINE = H_VISIBLE + H_FRONT_PORCH
                              + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE_FRAME = V_VISIBLE + V_FRONT_PORCH
                               + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int X_BITS       = $clog2(H_WHOLE_LINE),
  localparam int Y_BITS       = $clog2(V_WHOLE_FRAME)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  vga_stream_out_if.slave       s,
  output logic [COLOR_BITS-1:0] vga_red,
  output logic [COLOR_BITS-1:0] vga_grn,
  output logic [COLOR_BITS-1:0] vga_blu,
  output logic [META_BITS-1:0]  vga_meta,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_de,
  output logic [X_BITS-1:0]     vga_x,
  output logic [Y_BITS-1:0]     vga_y,
  output logic                  frame_start,
  output logic                  err_pulse,
  output logic [ERR_BITS-1:0]   err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RUN
  } state_t;

  localparam logic [X_BITS-1:0] X_LAST =
    X_BITS'(H_WHOLE_LINE - 1);
  localparam logic [X_BITS-1:0] X_VIS =
    X_BITS'(H_VISIBLE);
  localparam logic [X_BITS-1:0] HS_BEG =
    X_BITS'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [X_BITS-1:0] HS_END =
    X_BITS'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);

  localparam logic [Y_BITS-1:0] Y_LAST =
    Y_BITS'(V_WHOLE_FRAME - 1);
  localparam logic [Y_BITS-1:0] Y_VIS =
    Y_BITS'(V_VISIBLE);
  localparam logic [Y_BITS-1:0] VS_BEG =
    Y_BITS'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [Y_BITS-1:0] VS_END =
    Y_BITS'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

  localparam logic H_ACT = (H_SYNC_POL != 0);
  localparam logic V_ACT = (V_SYNC_POL != 0);

  state_t            state_q;
  state_t            state_d;
  logic [X_BITS-1:0] x_q;
  logic [X_BITS-1:0] x_d;
  logic [Y_BITS-1:0] y_q;
  logic [Y_BITS-1:0] y_d;

  logic vis;
  logic origin;
  logic at_last;
  logic hs_on;
  logic vs_on;
  logic ready;
  logic show;
  logic err;
  logic live;

  always_comb begin
    vis     = (x_q < X_VIS) && (y_q < Y_VIS);
    origin  = (x_q == '0) && (y_q == '0);
    at_last = (x_q == X_LAST) && (y_q == Y_LAST);
    hs_on   = (x_q >= HS_BEG) && (x_q < HS_END);
    vs_on   = (y_q >= VS_BEG) && (y_q < VS_END);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!enable || state_q == IDLE) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == X_LAST) begin
      x_d = '0;
      if (y_q == Y_LAST) begin
        y_d = '0;
      end else begin
        y_d = y_q + 1'b1;
      end
    end else begin
      x_d = x_q + 1'b1;
    end
  end

  // In RUN a beat at (0,0) must carry SOF and any other visible beat
  // must not. A stray SOF is left in the stream so WAIT can resync on it.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    show    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        ready = s.valid && !s.sof;
        if (at_last && s.valid && s.sof) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (vis) begin
          ready = origin || !s.sof;
          err   = !s.valid || (s.sof != origin);
          show  = !err;
          if (err) begin
            state_d = WAIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
    end
  end

  assign s.ready = ready;

  // Disabling blanks the outputs on the very next edge.
  assign live = enable && (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x     <= '0;
      vga_y     <= '0;
      vga_de    <= 1'b0;
      vga_hsync <= !H_ACT;
      vga_vsync <= !V_ACT;
    end else begin
      vga_x     <= live ? x_q : '0;
      vga_y     <= live ? y_q : '0;
      vga_de    <= live && vis;
      vga_hsync <= (live && hs_on) ? H_ACT : !H_ACT;
      vga_vsync <= (live && vs_on) ? V_ACT : !V_ACT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_red     <= '0;
      vga_grn     <= '0;
      vga_blu     <= '0;
      vga_meta    <= '0;
      frame_start <= 1'b0;
    end else if (live && show) begin
      vga_red     <= s.pixel[PIXEL_BITS-1 -: COLOR_BITS];
      vga_grn     <= s.pixel[2*COLOR_BITS-1 -: COLOR_BITS];
      vga_blu     <= s.pixel[COLOR_BITS-1:0];
      vga_meta    <= s.meta;
      frame_start <= origin;
    end else begin
      vga_red     <= '0;
      vga_grn     <= '0;
      vga_blu     <= '0;
      vga_meta    <= '0;
      frame_start <= 1'b0;
    end
  end

  // Errors are counted even when enable drops in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= err;
      if (err && err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
